// File: rtl/stopwatch_lap_timer.sv
// Purpose : BCD stopwatch / countdown timer (MM:SS.t) with prescaler, preset load and lap capture.
// Latency : buttons act 3 clk edges after their rise; clr/load act on the next edge; count moves on the tick edge.
// Backpres: none; outputs are free-running levels and single-cycle pulses, no handshake.
//
// Ports: clk/rst (async active-high); start/stop/lap async buttons (synchronised, rise-detected);
//        clr level clear; load strobe with 20-bit BCD preset; dir 1=up 0=down; count BCD time;
//        running/expired state flags; done and load_err one-cycle pulses; lap_time/lap_valid capture.
// Build option: define STOPWATCH_LAP_EN to build lap capture; otherwise lap is ignored and its outputs tie to 0.
module stopwatch_lap_timer #(
   parameter int TICK_DIV  = 10_000_000,
   parameter int MIN_LIMIT = 59
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        lap,
   input  logic        clr,
   input  logic        load,
   input  logic        dir,
   input  logic [19:0] preset,
   output logic [19:0] count,
   output logic        running,
   output logic        expired,
   output logic        done,
   output logic        load_err,
   output logic [19:0] lap_time,
   output logic        lap_valid
);

   localparam int          PW      = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
   localparam logic [3:0]  LIM_MSD = 4'(MIN_LIMIT / 10);
   localparam logic [3:0]  LIM_LSD = 4'(MIN_LIMIT % 10);
   localparam logic [19:0] TERM_UP = {LIM_MSD, LIM_LSD, 4'd5, 4'd9, 4'd9};

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   presc, presc_nxt;
   logic [19:0]     count_nxt, stepped;
   logic            done_nxt, err_nxt;
   logic            tick, load_ok, preset_ok;

   // Synchroniser chains reset high: a button held through reset looks already
   // pressed, so it must be released and pressed again to produce an edge.
   logic [2:0] start_sync, stop_sync;
   logic       start_edge, stop_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_sync <= '1;
         stop_sync  <= '1;
      end else begin
         start_sync <= {start_sync[1:0], start};
         stop_sync  <= {stop_sync[1:0], stop};
      end
   end

   assign start_edge = start_sync[1] & ~start_sync[2];
   assign stop_edge  = stop_sync[1]  & ~stop_sync[2];

   function automatic logic is_term(input logic [19:0] c, input logic up);
      return up ? (c == TERM_UP) : (c == 20'd0);
   endfunction

   // One tenth step with the carry/borrow rippling through every digit in one pass.
   // Callers guarantee c is not terminal, so minutes never leave 00..MIN_LIMIT.
   function automatic logic [19:0] bcd_step(input logic [19:0] c, input logic up);
      logic [3:0] d4, d3, d2, d1, d0;
      {d4, d3, d2, d1, d0} = c;
      if (up) begin
         if (d0 != 4'd9) d0 = d0 + 4'd1;
         else begin
            d0 = 4'd0;
            if (d1 != 4'd9) d1 = d1 + 4'd1;
            else begin
               d1 = 4'd0;
               if (d2 != 4'd5) d2 = d2 + 4'd1;
               else begin
                  d2 = 4'd0;
                  if (d3 != 4'd9) d3 = d3 + 4'd1;
                  else begin
                     d3 = 4'd0;
                     d4 = d4 + 4'd1;
                  end
               end
            end
         end
      end else begin
         if (d0 != 4'd0) d0 = d0 - 4'd1;
         else begin
            d0 = 4'd9;
            if (d1 != 4'd0) d1 = d1 - 4'd1;
            else begin
               d1 = 4'd9;
               if (d2 != 4'd0) d2 = d2 - 4'd1;
               else begin
                  d2 = 4'd5;
                  if (d3 != 4'd0) d3 = d3 - 4'd1;
                  else begin
                     d3 = 4'd9;
                     d4 = d4 - 4'd1;
                  end
               end
            end
         end
      end
      return {d4, d3, d2, d1, d0};
   endfunction

   // Minute digits compare as one 8-bit BCD value once both digits are known to be <= 9.
   assign preset_ok = (preset[3:0] <= 4'd9) && (preset[7:4] <= 4'd9) && (preset[11:8] <= 4'd5) &&
                      (preset[15:12] <= 4'd9) && (preset[19:16] <= 4'd9) &&
                      ({preset[19:16], preset[15:12]} <= {LIM_MSD, LIM_LSD});
   assign load_ok   = load && (state != RUN) && preset_ok;
   assign tick      = (state == RUN) && (presc == PMAX);
   assign stepped   = bcd_step(count, dir);

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      presc_nxt = presc;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (clr) begin
         state_nxt = IDLE;
         count_nxt = '0;
         presc_nxt = '0;
      end else if (load_ok) begin
         state_nxt = PAUSE;
         count_nxt = preset;
         presc_nxt = '0;
      end else begin
         err_nxt = load;
         case (state)
            RUN: begin
               presc_nxt = tick ? '0 : presc + PW'(1);
               if (tick) begin
                  // Already terminal (e.g. after a dir change) finishes without moving.
                  if (is_term(count, dir)) begin
                     state_nxt = DONE;
                     done_nxt  = 1'b1;
                  end else begin
                     count_nxt = stepped;
                     if (is_term(stepped, dir)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                     end
                  end
               end
               if (!done_nxt && stop_edge) state_nxt = PAUSE;
            end
            IDLE, PAUSE: begin
               if (start_edge && !is_term(count, dir))
                  state_nxt = stop_edge ? PAUSE : RUN;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         presc    <= '0;
         done     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         presc    <= presc_nxt;
         done     <= done_nxt;
         load_err <= err_nxt;
      end
   end

   assign running = (state == RUN);
   assign expired = (state == DONE);

`ifdef STOPWATCH_LAP_EN
   logic [2:0] lap_sync;
   logic       lap_edge;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lap_sync <= '1;
      else     lap_sync <= {lap_sync[1:0], lap};
   end

   assign lap_edge = lap_sync[1] & ~lap_sync[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lap_time  <= '0;
         lap_valid <= 1'b0;
      end else if (clr) begin
         lap_time  <= '0;
         lap_valid <= 1'b0;
      end else if (lap_edge && (state == RUN || state == PAUSE)) begin
         lap_time  <= count;
         lap_valid <= 1'b1;
      end
   end
`else
   logic unused_lap;
   assign unused_lap = lap;
   assign lap_time   = '0;
   assign lap_valid  = 1'b0;
`endif

endmodule

// File: doc/stopwatch_lap_timer.md
# stopwatch_lap_timer

Parametrised BCD stopwatch / countdown timer. It is the next-generation replacement for the single-minute-digit stopwatch and adds:
- a configurable tick prescaler,
- two minute digits with a configurable upper limit,
- preset load for countdown use,
- lap capture, and
- an explicit run/pause/done state machine.

Everything runs in the single `clk` domain; there are no derived clocks. It sits between the board button/switch inputs and the seven-segment display driver.

## Interface
Parameters:
- TICK_DIV, default 10_000_000: `clk` cycles per 0.1 s tick; legal range is 2 or more.
- MIN_LIMIT, default 59: highest minute value in up-count; legal range is 1..99.

Ports:
- clk  in  1  System clock; all logic is on the rising edge.
- rst  in  1  Reset: asynchronous, active-high.
- start  in  1  Start button, asynchronous; synchronised and rising-edge detected internally.
- stop  in  1  Stop button, asynchronous; synchronised and rising-edge detected internally.
- lap  in  1  Lap button, asynchronous; synchronised and rising-edge detected internally.
- clr  in  1  Synchronous clear, level-sensitive.
- load  in  1  Synchronous one-cycle strobe that loads `preset`.
- dir  in  1  Count direction: 1 = up, 0 = down. Sampled on each tick.
- preset  in  20  BCD digits {min_msd, min_lsd, sec_msd, sec_lsd, tenth}.
- count  out  20  Current time, same BCD packing as `preset`.
- running  out  1  High when the state is RUN.
- expired  out  1  High when the state is DONE.
- done  out  1  One-cycle pulse on entry to DONE.
- load_err  out  1  One-cycle pulse when a load is rejected.
- lap_time  out  20  Captured lap time.
- lap_valid  out  1  High once a lap has been captured.

## Operation
- States:
  - IDLE: reset value, or after `clr`.
  - RUN
  - PAUSE
  - DONE
- Terminal value:
  - Up-count (`dir`=1): MIN_LIMIT:59.9.
  - Down-count (`dir`=0): 00:00.0.
- Transitions:
  - IDLE/PAUSE → RUN on a start edge, unless `count` is already at the terminal value for the current `dir`. In that case the start edge is ignored.
  - RUN → PAUSE on a stop edge.
  - RUN → DONE on the tick whose update produces the terminal value. `done` pulses on that same edge.
  - DONE is left only by `clr` (→ IDLE) or by an accepted `load` (→ PAUSE).
  - `clr` from any state → IDLE. `count`, the prescaler, `lap_time` and `lap_valid` all go to 0.
- Priority within one cycle: `rst` > `clr` > stop edge > start edge. A start and a stop in the same cycle leave the block in, or move it to, PAUSE.
- Prescaler:
  - Counts 0..TICK_DIV-1, and only in RUN.
  - A tick is generated when it wraps from TICK_DIV-1 to 0.
  - It holds its value in PAUSE, so a resumed run keeps the partial tick.
  - It is cleared by `clr`, `rst` and accepted `load`.
- BCD arithmetic on each tick:
  - tenth and sec_lsd count 0-9.
  - sec_msd counts 0-5.
  - Minutes are a two-digit BCD value 00..MIN_LIMIT.
  - Carries and borrows ripple combinationally, so the whole `count` updates in one edge.
  - `count` never goes past the terminal value, and never wraps.
- Load:
  - Accepted only in IDLE, PAUSE or DONE, and only when `preset` is valid. Valid means every digit ≤9, sec_msd ≤5 and minutes ≤ MIN_LIMIT.
  - Accepted: `count` = `preset` on the next edge, and the state becomes PAUSE. If the block was in IDLE and the preset is non-zero, it also becomes PAUSE.
  - Rejected (invalid preset, or state is RUN): `load_err` pulses and nothing else changes.
- Lap: a lap edge in RUN or PAUSE copies `count` into `lap_time` and sets `lap_valid`. A later lap edge overwrites the captured value. Lap edges in IDLE or DONE are ignored.
- A change of `dir` mid-run takes effect on the next tick. If the current value is already terminal for the new `dir`, the block enters DONE on that tick.

## Timing
- Reset values: state IDLE; `count`, `lap_time` = 0; `running`, `expired`, `done`, `load_err`, `lap_valid` = 0.
- `start`, `stop` and `lap` pass through a 2-flop synchroniser, then an edge detector. An input rise acts on the 3rd rising edge of `clk` after the rise (for example, `running` goes high 3 cycles after `start` rises).
- `clr` and `load` act on the next edge (1-cycle latency).
- The first tick after RUN entry from a zeroed prescaler occurs TICK_DIV cycles later. `count` changes on the same edge as the tick.
- `done` is high for exactly one cycle. `expired` stays high for as long as the state is DONE.
- A `rst` asserted mid-run clears everything asynchronously. The synchroniser flops also reset, so a button held through reset produces no edge.

## Configuration
- `STOPWATCH_LAP_EN`:
  - Defined: lap capture is present as described above.
  - Not defined: the lap synchroniser and the capture registers are not built, the `lap` input is ignored, and `lap_time` = 0 and `lap_valid` = 0 are tied constants.
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use TICK_DIV=4 and MIN_LIMIT=59.
- Up-count wrap: `dir`=1, start, run 100 ticks → `count` = 00:10.0. The tick taking 00:59.9 to 01:00.0 updates all digits on one edge.
- Up-count saturation: load 59:59.8 with `dir`=1, start, 1 tick → `count` = 59:59.9, DONE, `done` pulses once. Further start edges are ignored.
- Countdown: load 00:01.0 with `dir`=0, start → DONE after 10 ticks (40 cycles) at 00:00.0. Load 00:70.0 → `load_err`, `count` unchanged.
- Pause/resume: stop in RUN 2 cycles into a tick period, wait 50 cycles, start → the next tick comes 2 cycles after RUN re-entry. Start and stop in the same cycle → PAUSE.
- Lap and clear: lap at 00:03.4 while running → `lap_time` = 00:03.4, `lap_valid`=1, and `count` keeps advancing. `clr` → all outputs 0 and state IDLE. Build without `STOPWATCH_LAP_EN` → `lap_valid` stays 0.
- Reset mid-run: assert `rst` with `start` held high → all outputs 0 asynchronously. After release, no RUN entry occurs until `start` falls and rises again.
